// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud settings
// used by both the transmit and receive controllers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 163;
  localparam int DEF_DVSR_W  = 8;

endpackage

// File: rtl/uart_tx_ctrl_baud_gen.sv
// Free-running oversample tick generator: one-cycle s_tick every DVSR clocks.
// Shared between the transmit and receive controllers.
module baud_gen #(
  parameter int DVSR   = 163,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic reset,
  output logic s_tick
);

  localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] count;

  assign s_tick = (count == LAST);

  // wrap counter 0..DVSR-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + DVSR_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmit controller: pops one byte per frame from a show-ahead FIFO
// and shifts it out LSB-first at 16x oversampling.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int DVSR    = DEF_DVSR,
  parameter int DVSR_W  = DEF_DVSR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int S_W = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [S_W-1:0] LAST_OS = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] LAST_SB = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] LAST_N  = N_W'(DBIT - 1);

  logic            s_tick;
  state_t          state;
  logic [S_W-1:0]  s;
  logic [N_W-1:0]  n;
  logic [DBIT-1:0] b;

  baud_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick)
  );

  // Pop is gated by reset so no word is consumed while the block is held.
  assign fifo_rd      = !reset && (state == IDLE) && !fifo_empty;
  assign tx_busy      = (state != IDLE) || fifo_rd;
  assign tx_done_tick = (state == STOP) && s_tick && (s == LAST_SB);

  // frame sequencer; tx is loaded alongside each state/shift update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            b     <= fifo_r_data;
            s     <= '0;
            state <= START;
            tx    <= 1'b0;
          end else begin
            tx    <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == LAST_OS) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
              tx    <= b[0];
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == LAST_OS) begin
              s <= '0;
              b <= b >> 1;
              if (n == LAST_N) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                n  <= n + N_W'(1);
                tx <= b[1];
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == LAST_SB) begin
              state <= IDLE;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller that reads bytes from the TX FIFO and sends them on the serial line. It pops one byte per frame through the FIFO's read side (rd/empty/r_data) and shifts it out LSB-first as 8N1 at 16x oversampling. An internal baud tick generator sets the bit timing. It sits between the TX FIFO_buffer and the tx pin, and mirrors the receiver on the RX side.

Parameters:
DBIT, 8, data bits per frame; also the width of fifo_r_data.
SB_TICK, 16, number of oversample ticks in the stop phase (16 = 1 stop bit, 24 = 1.5, 32 = 2).
DVSR, 163, clock cycles per oversample tick (clk / (16 * baud)); minimum value 2.
DVSR_W, 8, baud counter width; must satisfy 2**DVSR_W >= DVSR.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
fifo_empty  in  1  FIFO empty flag.
fifo_r_data  in  DBIT  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
fifo_rd  out  1  one-cycle pop strobe to the FIFO.
tx  out  1  serial line; idles high.
tx_busy  out  1  high from the pop cycle to the end of the stop phase.
tx_done_tick  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Single clock domain. Reset is asynchronous, active-high, and named reset.
- Reset values: tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, state=IDLE; tick count s=0, bit count n=0, shift register b=0, baud counter=0.
- Baud generator: free-running counter 0..DVSR-1. s_tick=1 in the cycle where count==DVSR-1, then the counter wraps to 0. It is not synchronised to frame start, so the first start bit may be up to DVSR-1 cycles short of 16 ticks. This is accepted.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0: fifo_rd=1 combinationally for that cycle; b<=fifo_r_data at the same edge; s<=0; next state START.
  - fifo_rd is never asserted while fifo_empty=1.
  - fifo_rd is never asserted outside IDLE, and never on two consecutive cycles.
- START:
  - tx=0.
  - On each s_tick: if s==15 then s<=0, n<=0, go to DATA; else s<=s+1.
- DATA:
  - tx=b[0].
  - On each s_tick: if s==15 then s<=0 and b<=b>>1. If n==DBIT-1 go to STOP, else n<=n+1. Otherwise s<=s+1.
- STOP:
  - tx=1.
  - On each s_tick: if s==SB_TICK-1 then tx_done_tick=1 for that cycle and go to IDLE; else s<=s+1.
- Frame length: (1+DBIT)*16 + SB_TICK ticks. With defaults: 160 ticks = 160*DVSR cycles, +/- one tick of start phase.
- tx_busy=1 in all states except IDLE, and also in the IDLE cycle where fifo_rd=1.
- Back-to-back frames: if the FIFO is non-empty on the IDLE cycle after STOP, pop immediately. The line gap is then at most 1 clock beyond the stop bit.
- tx is glitch-free: driven from registered state and b only, never from fifo_r_data directly.
- A FIFO write arriving on the same edge as a pop has no effect on this block.
- Reset mid-frame: tx returns to 1 immediately. The byte in flight is discarded and not re-read, and no done pulse is generated.
- A deasserting fifo_empty mid-frame is ignored until IDLE.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - OVERSAMPLE=16;
  - default DBIT, SB_TICK and DVSR, also used by the receiver.
- Sub-module baud_gen (params DVSR, DVSR_W; ports clk, reset, s_tick). It is shared with uart_rx.
- Top uart_tx_ctrl instantiates baud_gen plus the FSM/datapath.

Test Plan:
1. Reset held 3 cycles, FIFO empty (DVSR=2) -> tx=1, fifo_rd=0, tx_busy=0 throughout; no pop for 200 cycles after release.
2. FIFO holds 8'b0000_1111 (DVSR=2) -> exactly one fifo_rd pulse. tx shows 0 for 32 cycles (+/-1 tick), then bits 1,1,1,1,0,0,0,0 for 32 cycles each, then 1 for 32 cycles. tx_done_tick pulses once; tx_busy spans the frame.
3. FIFO holds 0x0F, 0x0E, 0x0C, 0x08 -> four frames in that order, four fifo_rd pulses, four done ticks. The IDLE gap between frames is at most 1 cycle; fifo_rd is never asserted with fifo_empty=1.
4. Byte 0x6C written while a frame is in progress -> no pop until STOP completes, then 0x6C is sent with decoded bits 0,0,1,1,0,1,1,0.
5. Reset asserted during DATA bit 3 of 0xA5 -> tx=1 in the same cycle (asynchronous). After release, no done tick and no spurious start bit; the next FIFO byte is sent normally.
6. SB_TICK=32, DVSR=2 -> stop phase of 64 cycles before the next start bit; the receiver model decodes 0x55 with no framing error.
